ct_decrypt: RTL and testbench
=============================

CT_DECRYPT -- requirements
Module: ct_decrypt

Interface
REQ-001 Parameters: none; all sizing comes from the shared package constants N_SLOTS_L (8), W_BITS (16), Q_MOD (7710), T_MOD (257), DELTA (30).
REQ-002 Ports are clocked on clk, with asynchronous active-low reset rst_n.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  ciphertext/key pair offered.
REQ-006 in_ready  output  1  block can accept a new job.
REQ-007 in_ct  input  CT_t  ciphertext (A, B vectors, each slot < Q_MOD).
REQ-008 in_sk  input  vec_t  secret key, one word per slot, each < Q_MOD.
REQ-009 out_valid  output  1  decrypted plaintext available.
REQ-010 out_ready  input  1  consumer accepts out_pt.
REQ-011 out_pt  output  PT_t  recovered plaintext, each slot < T_MOD.
REQ-012 busy  output  1  high in CALC and DONE states.

Function
REQ-013 Per slot i: phase_i = (B_i - A_i*s_i) mod Q_MOD, computed as non-negative, with A_i*s_i at 2*W_BITS width before reduction.
REQ-014 Per slot i: m_i = floor((phase_i + DELTA/2) / DELTA) mod T_MOD. Because Q_MOD = DELTA*T_MOD, a phase near Q_MOD wraps to 0.
REQ-015 FSM states:
- IDLE: in_ready=1.
- CALC: slot counter 0..N_SLOTS_L-1.
- DONE: out_valid=1.
REQ-016 IDLE->CALC on in_valid&&in_ready; in_ct and in_sk are registered at that edge and later input changes are ignored.
REQ-017 CALC processes exactly one slot per cycle in ascending index order, writing out_pt[i]. CALC->DONE after slot N_SLOTS_L-1.
REQ-018 Latency: out_valid rises exactly N_SLOTS_L+1 cycles after the accept edge.
REQ-019 DONE holds out_valid and a stable out_pt until out_valid&&out_ready. It returns to IDLE on that edge.
REQ-020 in_ready is 0 in CALC and DONE. No back-to-back accept in the handoff cycle; the next job is accepted at the earliest one cycle after IDLE is re-entered.
REQ-021 The arithmetic does not saturate; every intermediate is reduced so no slot result is ever >= its modulus.

Reset
REQ-022 On rst_n=0, asynchronously: state=IDLE, slot counter=0, out_valid=0, busy=0, out_pt=all zero, in_ready=0 while reset is asserted. in_ready becomes 1 in the first cycle after release.
REQ-023 Reset during CALC or DONE aborts the job. No partial result is ever presented with out_valid=1.

Configuration
REQ-024 Macro CT_DECRYPT_NOISE_EN. When defined, the block adds output out_noise_warn (1 bit), valid with out_valid. It is set if any slot satisfies |phase_i - DELTA*round_i| > DELTA/4 (integer, 7), where round_i is the quotient before mod T_MOD.
REQ-025 When CT_DECRYPT_NOISE_EN is undefined, out_noise_warn and its logic are absent and all other behaviour is identical.

Structure
REQ-026 CT_t, PT_t, vec_t, N_SLOTS_L, W_BITS, Q_MOD, T_MOD and DELTA live in the shared types package/header. They are not redefined locally.
REQ-027 One sub-module, mod_q_mulsub, computes combinationally (B - A*s) mod Q_MOD for one slot. ct_decrypt instantiates it once and time-multiplexes it across slots.

Verification
REQ-028 Basic: A=100, s=1, B=250 in all slots -> after 9 cycles, out_pt=5 in every slot; noise_warn=0.
REQ-029 Wrap of the product: slot 0 with A=7709, s=2, B=88 -> phase=90, out_pt[0]=3.
REQ-030 Rounding edge: phase 44 -> m=1 (noise_warn=1 when enabled); phase 45 -> m=2; phase 7700 -> m=0.
REQ-031 Backpressure: out_ready held 0 for 5 cycles after out_valid -> out_pt stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE on the next edge.
REQ-032 Reset mid-CALC: assert rst_n=0 at slot 3 -> out_valid=0 and out_pt=0 immediately; the next job decrypts correctly.
REQ-033 Round trip: output of ct_pt_add with Γ=[1..8] applied to an encryption of 0 under s -> out_pt=[1,2,3,4,5,6,7,8].

Source files
------------

// File: rtl/ct_decrypt_pkg.sv
// Shared types and constants for the ct_decrypt block.
// Holds slot/word sizing, the ciphertext/plaintext/key vector types, the FSM
// state type and the per-slot rounding helpers used by the decoder.
package ct_decrypt_pkg;

  localparam int unsigned N_SLOTS_L = 8;
  localparam int unsigned W_BITS    = 16;
  localparam int unsigned Q_MOD     = 7710;
  localparam int unsigned T_MOD     = 257;
  localparam int unsigned DELTA     = 30;
  localparam int unsigned PT_BITS   = 9;
  localparam int unsigned SLOT_BITS = $clog2(N_SLOTS_L);
  // One extra count so the counter can mark the pipeline drain cycle.
  localparam int unsigned IDX_BITS  = $clog2(N_SLOTS_L + 1);

  typedef logic [W_BITS-1:0]  word_t;
  typedef logic [PT_BITS-1:0] pt_word_t;
  typedef word_t    [N_SLOTS_L-1:0] vec_t;
  typedef pt_word_t [N_SLOTS_L-1:0] PT_t;

  typedef struct packed {
    vec_t a;
    vec_t b;
  } CT_t;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  // Rounded quotient floor((phase + DELTA/2) / DELTA) before reduction mod T_MOD.
  function automatic pt_word_t round_quot(word_t phase);
    word_t sum;
    sum = phase + W_BITS'(DELTA / 2);
    return PT_BITS'(sum / W_BITS'(DELTA));
  endfunction

  // phase < Q_MOD = DELTA*T_MOD, so the quotient tops out at T_MOD: that one wraps to 0.
  function automatic pt_word_t decode_slot(pt_word_t rq);
    return (rq == PT_BITS'(T_MOD)) ? '0 : rq;
  endfunction

  function automatic logic noise_flag(word_t phase, pt_word_t rq);
    word_t centre;
    word_t diff;
    centre = W_BITS'(rq) * W_BITS'(DELTA);
    diff   = (phase >= centre) ? phase - centre : centre - phase;
    return diff > W_BITS'(DELTA / 4);
  endfunction

endpackage

// File: rtl/ct_decrypt_if.sv
// Handshake/data bundle for ct_decrypt.
// slave  : the decryptor (accepts jobs, produces plaintext).
// master : the requester (drives ct/sk, consumes plaintext).
// in_valid/in_ready/in_ct/in_sk : job input handshake.
// out_valid/out_ready/out_pt    : result handshake.
// busy                          : high while a job is held.
// out_noise_warn exists only when CT_DECRYPT_NOISE_EN is defined.
interface ct_decrypt_if;
  import ct_decrypt_pkg::*;

  logic in_valid;
  logic in_ready;
  CT_t  in_ct;
  vec_t in_sk;
  logic out_valid;
  logic out_ready;
  PT_t  out_pt;
  logic busy;
`ifdef CT_DECRYPT_NOISE_EN
  logic out_noise_warn;
`endif

  modport slave (
    input  in_valid, in_ct, in_sk, out_ready,
`ifdef CT_DECRYPT_NOISE_EN
    output out_noise_warn,
`endif
    output in_ready, out_valid, out_pt, busy
  );

  modport master (
    output in_valid, in_ct, in_sk, out_ready,
`ifdef CT_DECRYPT_NOISE_EN
    input  out_noise_warn,
`endif
    input  in_ready, out_valid, out_pt, busy
  );

endinterface

// File: rtl/ct_decrypt_mod_q_mulsub.sv
// mod_q_mulsub: combinational per-slot phase (b - a*s) mod Q_MOD, non-negative.
// a_i, b_i, s_i : slot operands (W_BITS each).
// phase_o       : reduced phase, always < Q_MOD.
module mod_q_mulsub
  import ct_decrypt_pkg::*;
(
  input  word_t a_i,
  input  word_t b_i,
  input  word_t s_i,
  output word_t phase_o
);

  logic [2*W_BITS-1:0] prod;
  word_t               prod_mod;
  word_t               b_mod;

  always_comb begin
    prod     = (2*W_BITS)'(a_i) * (2*W_BITS)'(s_i);
    prod_mod = W_BITS'(prod % (2*W_BITS)'(Q_MOD));
    b_mod    = b_i % W_BITS'(Q_MOD);
    // Both terms are reduced, so one conditional add of Q_MOD keeps the result in range.
    phase_o  = (b_mod >= prod_mod) ? b_mod - prod_mod
                                   : b_mod + (W_BITS'(Q_MOD) - prod_mod);
  end

endmodule

// File: rtl/ct_decrypt.sv
// ct_decrypt: slot-serial decryptor, one slot per cycle through a shared mod_q_mulsub.
// clk, rst_n : clock and asynchronous active-low reset.
// bus        : ct_decrypt_if.slave (job input, plaintext output, busy).
// Optional macro CT_DECRYPT_NOISE_EN adds bus.out_noise_warn.
// Two-stage slot pipeline (phase register, then decode), so the result
// appears N_SLOTS_L+1 cycles after the accepting edge.
module ct_decrypt
  import ct_decrypt_pkg::*;
(
  input logic         clk,
  input logic         rst_n,
  ct_decrypt_if.slave bus
);

  state_e                state_q;
  logic [IDX_BITS-1:0]   cnt_q;
  CT_t                   ct_q;
  vec_t                  sk_q;
  word_t                 phase_q;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic                  busy_q;
  PT_t                   out_pt_q;

  word_t                 phase_c;
  pt_word_t              round_c;
  logic [SLOT_BITS-1:0]  rd_idx;
  logic [SLOT_BITS-1:0]  wr_idx;

  assign rd_idx  = cnt_q[SLOT_BITS-1:0];
  assign wr_idx  = SLOT_BITS'(cnt_q - 1'b1);
  assign round_c = round_quot(phase_q);

  mod_q_mulsub u_mulsub (
    .a_i     (ct_q.a[rd_idx]),
    .b_i     (ct_q.b[rd_idx]),
    .s_i     (sk_q[rd_idx]),
    .phase_o (phase_c)
  );

`ifdef CT_DECRYPT_NOISE_EN
  logic noise_q;
  assign bus.out_noise_warn = noise_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      ct_q        <= '0;
      sk_q        <= '0;
      phase_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_pt_q    <= '0;
`ifdef CT_DECRYPT_NOISE_EN
      noise_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          in_ready_q <= 1'b1;
          if (bus.in_valid && in_ready_q) begin
            ct_q       <= bus.in_ct;
            sk_q       <= bus.in_sk;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= StCalc;
`ifdef CT_DECRYPT_NOISE_EN
            noise_q    <= 1'b0;
`endif
          end
        end
        StCalc: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q != IDX_BITS'(N_SLOTS_L)) begin
            phase_q <= phase_c;
          end
          // Slot cnt_q-1 leaves the phase register this cycle.
          if (cnt_q != '0) begin
            out_pt_q[wr_idx] <= decode_slot(round_c);
`ifdef CT_DECRYPT_NOISE_EN
            noise_q <= noise_q | noise_flag(phase_q, round_c);
`endif
          end
          if (cnt_q == IDX_BITS'(N_SLOTS_L)) begin
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_pt    = out_pt_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_ct_decrypt.sv
`timescale 1ns/1ps
module tb_ct_decrypt;
  import ct_decrypt_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ct_decrypt_if bus();

  ct_decrypt dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string name;
    vec_t  a;
    vec_t  b;
    vec_t  s;
    PT_t   exp_pt;
    logic  exp_noise;
  } vec_rec_t;

  typedef struct {
    PT_t  pt;
    logic noise;
  } exp_t;

  exp_t     sb[$];
  vec_rec_t vecs[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Independent reference: plain integer arithmetic per slot.
  function automatic void model(input vec_t a, input vec_t b, input vec_t s,
                                output PT_t pt, output logic nz);
    longint ph, r, d;
    nz = 1'b0;
    for (int i = 0; i < N_SLOTS_L; i++) begin
      ph = (longint'(b[i]) - longint'(a[i]) * longint'(s[i])) % longint'(Q_MOD);
      if (ph < 0) ph += Q_MOD;
      r = (ph + 15) / 30;
      pt[i] = PT_BITS'(r % 257);
      d = ph - 30 * r;
      if (d < 0) d = -d;
      if (d > 7) nz = 1'b1;
    end
  endfunction

  task automatic run_job(input vec_rec_t v, input bit bp);
    int   cyc;
    int   waitc;
    PT_t  held;
    exp_t e;
    waitc = 0;
    while (bus.in_ready !== 1'b1 && waitc < 20) begin
      @(posedge clk); #1; waitc++;
    end
    chk({v.name, " in_ready_before"}, bus.in_ready, 1'b1);
    bus.in_ct.a = v.a;
    bus.in_ct.b = v.b;
    bus.in_sk   = v.s;
    bus.in_valid = 1'b1;
    @(posedge clk);
    sb.push_back('{pt: v.exp_pt, noise: v.exp_noise});
    #1;
    bus.in_valid = 1'b0;
    // Inputs must be latched; scramble them after the accept edge.
    for (int i = 0; i < N_SLOTS_L; i++) begin
      bus.in_ct.a[i] = 16'($urandom);
      bus.in_ct.b[i] = 16'($urandom);
      bus.in_sk[i]   = 16'($urandom);
    end
    chk({v.name, " busy_calc"}, bus.busy, 1'b1);
    chk({v.name, " in_ready_calc"}, bus.in_ready, 1'b0);
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    chk({v.name, " latency"}, 128'(cyc), 128'(N_SLOTS_L + 1));
    if (bus.out_valid !== 1'b1) begin
      void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    chk({v.name, " out_pt"}, 128'(bus.out_pt), 128'(e.pt));
`ifdef CT_DECRYPT_NOISE_EN
    chk({v.name, " noise"}, bus.out_noise_warn, e.noise);
`endif
    if (bp) begin
      held = bus.out_pt;
      for (int k = 0; k < 5; k++) begin
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        chk({v.name, " bp_valid"}, bus.out_valid, 1'b1);
        chk({v.name, " bp_stable"}, 128'(bus.out_pt), 128'(held));
        chk({v.name, " bp_in_ready"}, bus.in_ready, 1'b0);
      end
      bus.in_valid = 1'b0;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({v.name, " done_exit"}, bus.out_valid, 1'b0);
    chk({v.name, " busy_idle"}, bus.busy, 1'b0);
    chk({v.name, " in_ready_idle"}, bus.in_ready, 1'b1);
  endtask

  initial begin
    vec_rec_t v;
    PT_t      pt;
    logic     nz;
    int       e;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_ct     = '0;
    bus.in_sk     = '0;

    // Basic: phase 150 -> 5 everywhere.
    v.name = "basic";
    for (int i = 0; i < N_SLOTS_L; i++) begin
      v.a[i] = 16'd100; v.s[i] = 16'd1; v.b[i] = 16'd250; v.exp_pt[i] = 9'd5;
    end
    v.exp_noise = 1'b0;
    vecs.push_back(v);

    // Product wrap and rounding edges.
    v.name = "edges";
    v.a = '0; v.s = '0; v.b = '0;
    v.a[0] = 16'd7709; v.s[0] = 16'd2;    v.b[0] = 16'd88;   // phase 90 -> 3
    v.b[1] = 16'd44;                                          // -> 1, noisy
    v.b[2] = 16'd45;                                          // -> 2
    v.b[3] = 16'd7700;                                        // -> 0
    v.b[4] = 16'd7709;                                        // -> 0
    v.a[6] = 16'd1;    v.s[6] = 16'd1;                        // phase 7709 -> 0
    v.a[7] = 16'd7709; v.s[7] = 16'd7709; v.b[7] = 16'd7709;  // phase 7708 -> 0
    v.exp_pt = '0;
    v.exp_pt[0] = 9'd3; v.exp_pt[1] = 9'd1; v.exp_pt[2] = 9'd2;
    v.exp_noise = 1'b1;
    vecs.push_back(v);

    // Random operands, reference from the model.
    for (int k = 0; k < 3; k++) begin
      v.name = $sformatf("rand%0d", k);
      for (int i = 0; i < N_SLOTS_L; i++) begin
        v.a[i] = 16'($urandom_range(0, Q_MOD - 1));
        v.s[i] = 16'($urandom_range(0, Q_MOD - 1));
        v.b[i] = 16'($urandom_range(0, Q_MOD - 1));
      end
      model(v.a, v.b, v.s, pt, nz);
      v.exp_pt = pt;
      v.exp_noise = nz;
      vecs.push_back(v);
    end

    // Reset state.
    #12;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_out_pt", 128'(bus.out_pt), 128'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_rst", bus.in_ready, 1'b1);

    for (int n = 0; n < vecs.size(); n++) run_job(vecs[n], n == 1);

    // Reset in the middle of CALC.
    v = vecs[0];
    bus.in_ct.a = v.a; bus.in_ct.b = v.b; bus.in_sk = v.s;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 1'b0);
    chk("midrst_out_pt", 128'(bus.out_pt), 128'd0);
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_in_ready", bus.in_ready, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    v.name = "after_rst";
    run_job(v, 1'b0);

    // Round trip: encryption of 0 plus DELTA*gamma, gamma = 1..8.
    v.name = "roundtrip";
    for (int i = 0; i < N_SLOTS_L; i++) begin
      v.a[i] = 16'($urandom_range(0, Q_MOD - 1));
      v.s[i] = 16'($urandom_range(0, Q_MOD - 1));
      e = int'($urandom_range(0, 14)) - 7;
      v.b[i] = 16'((longint'(v.a[i]) * longint'(v.s[i]) + longint'(e + 30 * (i + 1)) + 2 * Q_MOD)
                   % Q_MOD);
      v.exp_pt[i] = 9'(i + 1);
    end
    v.exp_noise = 1'b0;
    run_job(v, 1'b0);

    chk("scoreboard_empty", 128'(sb.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
